rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Multicycle control FSM that sequences the RV32I datapath over one shared instruction/data memory.
- Owns the instruction register (IR), the memory request handshake and the PC-write enable.
- Produces every datapath select: ImmSrc, ALUControl, ResultSrc, ALUSrc, PCSrc, RegWrite.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 64, max cycles mem_req may wait for mem_ready before bus error (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ReadData  input  32  shared memory read data (instruction or load data)
mem_ready  input  1  memory accepts/completes current request this cycle
alu_zero  input  1  ALU result == 0 (from datapath)
alu_lt  input  1  signed rs1 < rs2 (from datapath)
ir  output  32  latched instruction, drives datapath register/imm fields
mem_req  output  1  memory request valid
mem_write  output  1  request is a store
addr_src  output  1  0 = PC, 1 = ALUResult as memory address
pc_write  output  1  PC register load enable
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
ResultSrc  output  2  00 ALU, 01 ReadData, 10 ImmExt, 11 PC+4
ALUSrc  output  1  1 = ImmExt on ALU B
PCSrc  output  1  1 = PC target
RegWrite  output  1  register file write enable
halted  output  1  sticky halt flag
illegal  output  1  sticky: halt caused by unsupported opcode
bus_err  output  1  sticky: halt caused by memory timeout
instret  output  CNT_W  retired instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset (async) forces:
  - state = FETCH, ir = 0, instret = 0.
  - halted, illegal, bus_err = 0; wait counter = 0.
  - All strobes (mem_req, mem_write, pc_write, RegWrite) = 0.
  - Selects = 0.
- Outputs are Moore-decoded from state and ir only; no output depends combinationally on mem_ready.
- States and transitions:
  - FETCH: mem_req=1, addr_src=0. On mem_ready: ir <= ReadData, go to DECODE. Otherwise stay.
  - DECODE (1 cycle): classify ir[6:0].
    - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 branch, 1101111 JAL, 0110111 LUI → go to EXEC.
    - Any other opcode: go to HALT and set illegal.
  - EXEC: drive ALU selects.
    - R/I-ALU/LUI/JAL → WB.
    - LW/SW: ALUControl=ADD, ALUSrc=1, ImmSrc I or S → MEM.
    - Branch: ALUControl=SUB, ALUSrc=0. taken = BEQ zero, BNE !zero, BLT lt, BGE !lt (funct3 000/001/100/101). PCSrc=taken, pc_write=1, instret++ → FETCH.
    - Any other branch funct3: HALT with illegal.
  - MEM: mem_req=1, addr_src=1, mem_write=(SW). On mem_ready:
    - LW → WB.
    - SW → pc_write=1, PCSrc=0, instret++, → FETCH.
  - WB: RegWrite=1 unless ir[11:7]==0; pc_write=1, instret++, → FETCH.
    - ResultSrc: 01 for LW, 10 for LUI, 11 for JAL, else 00.
    - PCSrc=1 only for JAL.
  - HALT: all strobes 0; stays until reset; halted=1.
- ALU decode:
  - R-type: funct3/funct7[5] map to the codes listed under ALUControl; funct7[5] selects SUB/SRA.
  - I-ALU: funct7[5] is honoured only for SRAI; ADDI never maps to SUB.
- Timeout: a wait counter increments each cycle mem_req=1 && !mem_ready and clears on handshake. When it reaches MEM_TIMEOUT: go to HALT, set bus_err, drop mem_req.
- pc_write is asserted exactly once per retired instruction, in the same cycle instret increments.
- Cycle counts with zero-wait memory: R/I/LUI/JAL 4, LW 5, SW 4, branch 3.
- Reset mid-MEM: request drops immediately (async), no register/PC write, instret unchanged.

Test Plan:
- reset, ReadData=0x002081B3 (add x3,x1,x2), mem_ready=1 → FETCH, DECODE, EXEC, WB. In WB: ALUControl=0000, ALUSrc=0, ResultSrc=00, RegWrite=1, pc_write=1. instret=1 after 4 cycles.
- ReadData=0x0000A183 (lw x3,0(x1)), mem_ready low 3 cycles in MEM → MEM lasts 4 cycles with addr_src=1, mem_write=0. WB has ResultSrc=01. Total 8 cycles.
- 0x00208463 (beq x1,x2,8):
  - alu_zero=1 → EXEC has ALUControl=0001, ImmSrc=010, PCSrc=1, pc_write=1.
  - alu_zero=0 → PCSrc=0.
- 0x00000013 addi x0 → WB with RegWrite=0, instret increments. ReadData=0xFFFFFFFF → HALT after DECODE, illegal=1, no pc_write.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=4 → HALT on 5th cycle, bus_err=1, mem_req=0 thereafter.
- SW 0x0020A023 with reset asserted mid-MEM → mem_req, mem_write drop same cycle, state FETCH after release, instret=0.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle RV32I control FSM over one shared
// instruction/data memory.
//   clk, reset                : clock (rising edge), async active-high reset
//   ReadData, mem_ready       : shared memory read data and handshake
//   alu_zero, alu_lt          : datapath compare flags used by branches
//   ir                        : latched instruction
//   mem_req/mem_write/addr_src: memory request, store flag, address select
//   pc_write, PCSrc           : PC load enable and target select
//   ImmSrc/ALUControl/ResultSrc/ALUSrc/RegWrite : datapath selects
//   halted/illegal/bus_err    : sticky halt status
//   instret                   : retired instruction count (wraps)
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ReadData,
  input  logic             mem_ready,
  input  logic             alu_zero,
  input  logic             alu_lt,
  output logic [31:0]      ir,
  output logic             mem_req,
  output logic             mem_write,
  output logic             addr_src,
  output logic             pc_write,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrc,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire, set_illegal, set_bus_err, sel_en;
  logic              mem_wait, timeout_hit, taken, br_f3_ok;
  logic [3:0]        alu_code;
  logic [2:0]        imm_code;
  logic              alu_src;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui, supported;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_br     = (opcode == OP_BR);
  assign is_jal    = (opcode == OP_JAL);
  assign is_lui    = (opcode == OP_LUI);
  assign supported = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_lui;

  assign br_f3_ok = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = ~alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = ~alu_lt;
      default: taken = 1'b0;
    endcase
  end

  // ALU operation decode; ir[30] only distinguishes SUB (R-type) and SRA/SRAI.
  always_comb begin
    alu_code = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_code = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_code = ALU_SLL;
        3'b010:  alu_code = ALU_SLT;
        3'b011:  alu_code = ALU_SLTU;
        3'b100:  alu_code = ALU_XOR;
        3'b101:  alu_code = ir[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_code = ALU_OR;
        default: alu_code = ALU_AND;
      endcase
    end else if (is_br) begin
      alu_code = ALU_SUB;
    end
  end

  always_comb begin
    imm_code = 3'b000;
    if (is_sw)  imm_code = 3'b001;
    if (is_br)  imm_code = 3'b010;
    if (is_jal) imm_code = 3'b011;
    if (is_lui) imm_code = 3'b100;
  end

  assign alu_src = ~(is_r | is_br);

  assign mem_wait    = (state == S_FETCH) || (state == S_MEM);
  assign timeout_hit = mem_wait && !mem_ready &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign halted      = (state == S_HALT);

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    addr_src    = 1'b0;
    pc_write    = 1'b0;
    RegWrite    = 1'b0;
    PCSrc       = 1'b0;
    ResultSrc   = 2'b00;
    ALUControl  = '0;
    ALUSrc      = 1'b0;
    ImmSrc      = '0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    sel_en      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (timeout_hit) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end else if (mem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (supported) begin
          state_next = S_EXEC;
        end else begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        sel_en = 1'b1;
        if (is_br) begin
          if (br_f3_ok) begin
            PCSrc      = taken;
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next  = S_HALT;
            set_illegal = 1'b1;
          end
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        sel_en    = 1'b1;
        mem_req   = 1'b1;
        addr_src  = 1'b1;
        mem_write = is_sw;
        if (timeout_hit) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end else if (mem_ready) begin
          if (is_sw) begin
            // A store retires in its MEM cycle, so pc_write must follow the
            // handshake to fire exactly once.
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        sel_en     = 1'b1;
        RegWrite   = (ir[11:7] != 5'd0);
        pc_write   = 1'b1;
        retire     = 1'b1;
        PCSrc      = is_jal;
        state_next = S_FETCH;
        if (is_lw)       ResultSrc = 2'b01;
        else if (is_lui) ResultSrc = 2'b10;
        else if (is_jal) ResultSrc = 2'b11;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (sel_en) begin
      ALUControl = alu_code;
      ALUSrc     = alu_src;
      ImmSrc     = imm_code;
    end
    // Strobes drop the moment reset rises, even though FETCH is the reset state.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      RegWrite  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_ready) ir <= ReadData;
      if (retire)      instret <= instret + 1'b1;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed and random instruction
// streams with random memory wait states, checked cycle by cycle against a
// per-instruction-class expectation model.
module tb_rv_multicycle_ctrl;
  localparam int TO = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ReadData = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic [31:0] ir;
  logic        mem_req, mem_write, addr_src, pc_write;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        ALUSrc, PCSrc, RegWrite, halted, illegal, bus_err;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ret = '0;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ReadData(ReadData), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .ir(ir), .mem_req(mem_req),
    .mem_write(mem_write), .addr_src(addr_src), .pc_write(pc_write),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .ALUSrc(ALUSrc), .PCSrc(PCSrc), .RegWrite(RegWrite), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sup(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI};
  endfunction

  // Operation table indexed by funct3: ADD SLL SLT SLTU XOR SRL OR AND.
  function automatic logic [3:0] exp_alu(input logic [31:0] in);
    logic [3:0] base [8];
    logic [2:0] f3;
    base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    f3 = in[14:12];
    if (in[6:0] == OP_R) begin
      if (in[30] && f3 == 3'd0) return 4'd1;
      if (in[30] && f3 == 3'd5) return 4'd9;
      return base[f3];
    end
    if (in[6:0] == OP_I) begin
      if (in[30] && f3 == 3'd5) return 4'd9;
      return base[f3];
    end
    if (in[6:0] == OP_BR) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      OP_SW:   return 3'd1;
      OP_BR:   return 3'd2;
      OP_JAL:  return 3'd3;
      OP_LUI:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Entered at a negedge; leaves at the negedge just after reset release.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_ir", ir, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_selects", {ALUControl, ImmSrc, ResultSrc, ALUSrc, PCSrc, addr_src}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_ret = '0;
  endtask

  task automatic expect_halt(input logic e_ill, input logic e_bus);
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom);
      ReadData = $urandom;
      #1;
      chk("halt_halted", halted, 1);
      chk("halt_illegal", illegal, e_ill);
      chk("halt_bus_err", bus_err, e_bus);
      chk("halt_strobes", {mem_req, mem_write, pc_write, RegWrite}, 0);
      chk("halt_instret", instret, model_ret);
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic do_instr(input logic [31:0] instr, input int fw, input int mw,
                          input logic z, input logic lt, input bit mid_rst);
    logic [6:0] op;
    logic [2:0] f3;
    logic       is_sw, is_br, legal_br, tk;
    op = instr[6:0];
    f3 = instr[14:12];
    is_sw = (op == OP_SW);
    is_br = (op == OP_BR);
    legal_br = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
    tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? lt : !lt;

    for (int i = 0; i <= fw; i++) begin
      if (i == TO) begin
        expect_halt(1'b0, 1'b1);
        return;
      end
      mem_ready = (i == fw);
      ReadData = (i == fw) ? instr : $urandom;
      alu_zero = 1'($urandom);
      #1;
      chk("fetch_mem_req", mem_req, 1);
      chk("fetch_addr_src", addr_src, 0);
      chk("fetch_wr_strobes", {mem_write, pc_write, RegWrite}, 0);
      chk("fetch_instret", instret, model_ret);
      @(negedge clk);
    end

    mem_ready = 1'($urandom);
    ReadData = $urandom;
    #1;
    chk("decode_ir", ir, instr);
    chk("decode_strobes", {mem_req, pc_write, RegWrite}, 0);
    @(negedge clk);
    if (!is_sup(op)) begin
      expect_halt(1'b1, 1'b0);
      return;
    end

    mem_ready = 1'($urandom);
    alu_zero = z;
    alu_lt = lt;
    #1;
    chk("exec_aluctl", ALUControl, exp_alu(instr));
    chk("exec_alusrc", ALUSrc, (op == OP_R || is_br) ? 0 : 1);
    chk("exec_immsrc", ImmSrc, exp_imm(op));
    chk("exec_strobes", {mem_req, RegWrite}, 0);
    if (is_br) begin
      chk("br_pc_write", pc_write, legal_br);
      if (legal_br) begin
        chk("br_pcsrc", PCSrc, tk);
        model_ret++;
        @(negedge clk);
      end else begin
        @(negedge clk);
        expect_halt(1'b1, 1'b0);
      end
      return;
    end
    chk("exec_pc_write", pc_write, 0);
    @(negedge clk);

    if (op == OP_LW || is_sw) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == TO) begin
          expect_halt(1'b0, 1'b1);
          return;
        end
        mem_ready = (i == mw) && !mid_rst;
        alu_zero = 1'($urandom);
        #1;
        chk("mem_req", mem_req, 1);
        chk("mem_addr_src", addr_src, 1);
        chk("mem_write", mem_write, is_sw);
        chk("mem_selects", {ALUControl, ALUSrc, ImmSrc}, {4'd0, 1'b1, exp_imm(op)});
        chk("mem_pc_write", pc_write, is_sw && mem_ready);
        chk("mem_regwrite", RegWrite, 0);
        if (mid_rst) begin
          #1 reset = 1'b1;
          #1;
          chk("midrst_strobes", {mem_req, mem_write, pc_write, RegWrite}, 0);
          @(negedge clk);
          reset = 1'b0;
          model_ret = '0;
          return;
        end
        if (is_sw && i == mw) model_ret++;
        @(negedge clk);
      end
      if (is_sw) return;
    end

    mem_ready = 1'($urandom);
    #1;
    chk("wb_regwrite", RegWrite, instr[11:7] != 5'd0);
    chk("wb_pc_write", pc_write, 1);
    chk("wb_resultsrc", ResultSrc,
        (op == OP_LW) ? 2'b01 : (op == OP_LUI) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00);
    chk("wb_pcsrc", PCSrc, op == OP_JAL);
    chk("wb_mem_req", mem_req, 0);
    chk("wb_aluctl", ALUControl, exp_alu(instr));
    model_ret++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    int          k;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [6:0]  op;
    logic [2:0]  brf [4];
    brf = '{3'd0, 3'd1, 3'd4, 3'd5};
    k = $urandom_range(0, 19);
    f3 = 3'($urandom);
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    imm = 12'($urandom);
    if (k < 4) begin
      return {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
              10'($urandom), f3, rd, OP_R};
    end else if (k < 8) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {imm, 5'($urandom), f3, rd, OP_I};
    end else if (k < 10) begin
      return {imm, 5'($urandom), 3'b010, rd, OP_LW};
    end else if (k < 12) begin
      return {imm[11:5], 10'($urandom), 3'b010, imm[4:0], OP_SW};
    end else if (k < 15) begin
      if ($urandom_range(0, 5) != 0) f3 = brf[$urandom_range(0, 3)];
      return {17'($urandom), f3, 5'($urandom), OP_BR};
    end else if (k < 17) begin
      return {20'($urandom), rd, OP_JAL};
    end else if (k < 19) begin
      return {20'($urandom), rd, OP_LUI};
    end
    op = 7'h7F;
    for (int t = 0; t < 16; t++) begin
      op = 7'($urandom);
      if (!is_sup(op)) break;
    end
    if (is_sup(op)) op = 7'h7F;
    return {25'($urandom), op};
  endfunction

  initial begin
    logic [31:0] instr;
    int fw, mw;
    @(negedge clk);
    do_reset();

    do_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0); // add x3,x1,x2
    do_instr(32'h0000A183, 0, 3, 1'b0, 1'b0, 1'b0); // lw x3,0(x1), 3 waits
    do_instr(32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0); // beq taken
    do_instr(32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0); // beq not taken
    do_instr(32'h00000013, 0, 0, 1'b0, 1'b0, 1'b0); // addi x0
    do_instr(32'h402081B3, 1, 0, 1'b0, 1'b0, 1'b0); // sub
    do_instr(32'h4030D193, 0, 0, 1'b0, 1'b0, 1'b0); // srai
    do_instr(32'h40008093, 0, 0, 1'b0, 1'b0, 1'b0); // addi with imm[10] set
    do_instr(32'h0020A023, 0, 0, 1'b0, 1'b0, 1'b1); // sw, reset mid-MEM
    do_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0); // illegal opcode
    do_instr(32'h002081B3, TO, 0, 1'b0, 1'b0, 1'b0); // fetch timeout
    do_instr(32'h0000A183, 0, TO, 1'b0, 1'b0, 1'b0); // mem timeout
    do_instr(32'h0000A183, TO - 1, TO - 1, 1'b0, 1'b0, 1'b0); // max wait
    do_instr(32'h0020A023, 0, TO - 1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0); // bne
    do_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, 1'b0); // blt
    do_instr(32'h0020D463, 0, 0, 1'b0, 1'b1, 1'b0); // bge
    do_instr(32'h0020E463, 0, 0, 1'b0, 1'b0, 1'b0); // bltu: unsupported

    for (int n = 0; n < 250; n++) begin
      instr = gen_instr();
      fw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, TO - 1);
      do_instr(instr, fw, mw, 1'($urandom), 1'($urandom), 1'b0);
    end

    mem_ready = 1'b0;
    #1;
    chk("final_instret", instret, model_ret);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
